// File: rtl/data_mem_responder.sv
// data_mem_responder: data-port responder for a single-cycle core.
// Combinational loads, stores committed on the rising edge. RAM below IO_BASE;
// I/O window at IO_BASE with TX FIFO (+0x0), STATUS (+0x4), RX mailbox (+0x8)
// and cycle counter (+0xC).
// Optional feature macro: RESPONDER_CYCLE_COUNTER_EN builds the cycle counter;
// without it CYCLE reads 0 and stores there are ignored.
module data_mem_responder #(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] IO_BASE    = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic        io_valid,
  output logic [31:0] io_data,
  input  logic        io_ready,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        overflow
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Byte-lane bits are don't-care for word accesses.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^address_to_mem[1:0];

  // Address decode on the word offset into the I/O window.
  logic        io_sel;
  logic [29:0] io_word;
  logic        tx_sel, status_sel, rx_sel, cyc_sel;
  logic [AW-1:0] ram_idx;

  assign io_sel     = (address_to_mem >= IO_BASE);
  assign io_word    = address_to_mem[31:2] - IO_BASE[31:2];
  assign tx_sel     = io_sel && (io_word == 30'd0);
  assign status_sel = io_sel && (io_word == 30'd1);
  assign rx_sel     = io_sel && (io_word == 30'd2);
  assign cyc_sel    = io_sel && (io_word == 30'd3);
  assign ram_idx    = address_to_mem[AW+1:2];

  // Storage arrays (not reset).
  logic [31:0] ram_q  [MEM_WORDS];
  logic [31:0] fifo_q [FIFO_DEPTH];

  // TX FIFO state.
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          fifo_full, fifo_empty, pop, push_req, push_ok;

  // RX mailbox state.
  logic          rx_valid_q, rx_valid_d;
  logic [31:0]   rx_data_q, rx_data_d;
  logic          rx_ack, rx_capture;

  logic [31:0]   cycle_rd;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign pop        = !fifo_empty && io_ready;
  assign push_req   = WE && tx_sel;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok    = push_req && (!fifo_full || pop);

  assign io_valid = !fifo_empty;
  assign io_data  = fifo_q[head_q];
  assign overflow = overflow_q;

  assign in_ready   = !rx_valid_q;
  assign rx_ack     = WE && rx_sel;
  assign rx_capture = in_valid && !rx_valid_q;

  // Next-state for FIFO pointers, overflow flag and mailbox.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;

    if (pop)     head_d = head_q + 1'b1;
    if (push_ok) tail_d = tail_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;

    // A dropped push outranks a STATUS-store clear.
    if (push_req && !push_ok)   overflow_d = 1'b1;
    else if (WE && status_sel)  overflow_d = 1'b0;

    // Capture only happens with the mailbox empty, so an acknowledge of a
    // full mailbox always wins; an acknowledge of an empty one is a no-op
    // and must not discard a word the producer has already handed over.
    if (rx_capture) begin
      rx_valid_d = 1'b1;
      rx_data_d  = in_data;
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // RAM and FIFO storage writes.
  always_ff @(posedge clk) begin
    if (WE && !io_sel) ram_q[ram_idx] <= data_to_mem;
    if (push_ok)       fifo_q[tail_q] <= data_to_mem;
  end

`ifdef RESPONDER_CYCLE_COUNTER_EN
  logic [31:0] cycle_q, cycle_d;

  // Free-running counter; a store overrides the increment.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (WE && cyc_sel) cycle_d = data_to_mem;
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cycle_q <= '0;
    else          cycle_q <= cycle_d;
  end

  assign cycle_rd = cycle_q;
`else
  assign cycle_rd = 32'd0;
`endif

  // Load data mux.
  always_comb begin
    data_from_mem = 32'd0;
    if (!io_sel)
      data_from_mem = ram_q[ram_idx];
    else if (status_sel)
      data_from_mem = {16'd0, 8'(count_q), 4'd0, overflow_q, rx_valid_q,
                       fifo_empty, fifo_full};
    else if (rx_sel)
      data_from_mem = rx_valid_q ? rx_data_q : 32'd0;
    else if (cyc_sel)
      data_from_mem = cycle_rd;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (default parameters).
module tb_data_mem_responder;

  localparam logic [31:0] IOB    = 32'h8000_0000;
  localparam logic [31:0] A_TX   = IOB;
  localparam logic [31:0] A_STAT = IOB + 32'h4;
  localparam logic [31:0] A_RX   = IOB + 32'h8;
  localparam logic [31:0] A_CYC  = IOB + 32'hC;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        WE;
  logic [31:0] address_to_mem, data_to_mem, data_from_mem;
  logic        io_valid, io_ready;
  logic [31:0] io_data;
  logic        in_valid, in_ready, overflow;
  logic [31:0] in_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .WE             (WE),
    .address_to_mem (address_to_mem),
    .data_to_mem    (data_to_mem),
    .data_from_mem  (data_from_mem),
    .io_valid       (io_valid),
    .io_data        (io_data),
    .io_ready       (io_ready),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .overflow       (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Combinational load, checked 1 ns after the address settles.
  task automatic ld(input logic [31:0] a, input logic [31:0] exp, input string tag);
    WE = 1'b0;
    address_to_mem = a;
    #1;
    chk(tag, data_from_mem, exp);
  endtask

  // Store committed at the next rising edge; returns 1 ns after it.
  task automatic st(input logic [31:0] a, input logic [31:0] d);
    WE = 1'b1;
    address_to_mem = a;
    data_to_mem = d;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] drain_exp [4];
  logic [31:0] cyc_e0, cyc_e1, cyc_e2;

  initial begin
    drain_exp[0] = 32'd2; drain_exp[1] = 32'd3;
    drain_exp[2] = 32'd4; drain_exp[3] = 32'd9;
`ifdef RESPONDER_CYCLE_COUNTER_EN
    cyc_e0 = 32'hFFFF_FFFE; cyc_e1 = 32'hFFFF_FFFF; cyc_e2 = 32'h0;
`else
    cyc_e0 = 32'h0; cyc_e1 = 32'h0; cyc_e2 = 32'h0;
`endif
    reset_n = 1'b1; WE = 1'b0; address_to_mem = '0; data_to_mem = '0;
    io_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_io_valid", 32'(io_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    ld(A_STAT, 32'h0000_0002, "rst_status");
    #14 reset_n = 1'b1;
    step();

    // RAM store/load and aliasing.
    st(32'h10, 32'h1234_5678);
    ld(32'h10, 32'h1234_5678, "ram_load");
    ld(32'h10 + 32'd4096, 32'h1234_5678, "ram_alias");
    st(32'h14, 32'hDEAD_BEEF);
    ld(32'h10, 32'h1234_5678, "ram_neighbour");
    ld(32'h14, 32'hDEAD_BEEF, "ram_load2");

    // Unmapped I/O offset: load 0, store ignored.
    st(IOB + 32'h10, 32'h55);
    ld(IOB + 32'h10, 32'h0, "io_unmapped");

    // Fill TX with io_ready low: 5th push dropped.
    for (int i = 1; i <= 5; i++) st(A_TX, 32'(i));
    ld(A_STAT, 32'h0000_0409, "tx_full_status");
    chk("tx_overflow_set", 32'(overflow), 32'd1);
    chk("tx_head", io_data, 32'd1);
    ld(A_TX, 32'h0, "tx_load_zero");

    // STATUS store clears overflow.
    st(A_STAT, 32'h0);
    chk("ovf_clear", 32'(overflow), 32'd0);
    ld(A_STAT, 32'h0000_0401, "status_after_clear");

    // Full FIFO, pop and push of 9 in the same cycle.
    io_ready = 1'b1;
    st(A_TX, 32'd9);
    io_ready = 1'b0;
    ld(A_STAT, 32'h0000_0401, "full_poppush_status");
    chk("full_poppush_ovf", 32'(overflow), 32'd0);
    chk("head_after_pop", io_data, 32'd2);
    step();
    chk("head_stable", io_data, 32'd2);

    // Drain.
    io_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", 32'(io_valid), 32'd1);
      chk("drain_data", io_data, drain_exp[i]);
      step();
    end
    chk("drain_empty", 32'(io_valid), 32'd0);
    io_ready = 1'b0;

    // Cycle counter load and wrap.
    st(A_CYC, 32'hFFFF_FFFE);
    ld(A_CYC, cyc_e0, "cycle_loaded");
    step();
    ld(A_CYC, cyc_e1, "cycle_plus1");
    step();
    ld(A_CYC, cyc_e2, "cycle_wrap");

    // RX mailbox.
    step();
    in_valid = 1'b1; in_data = 32'hAB;
    #1;
    chk("rx_ready_idle", 32'(in_ready), 32'd1);
    step();
    chk("rx_ready_low", 32'(in_ready), 32'd0);
    ld(A_RX, 32'hAB, "rx_first");
    ld(A_STAT, 32'h0000_0006, "rx_status");
    in_data = 32'hCD;
    step();
    ld(A_RX, 32'hAB, "rx_held_off");
    st(A_RX, 32'h0);
    chk("rx_ack_ready", 32'(in_ready), 32'd1);
    ld(A_RX, 32'h0, "rx_empty_load");
    step();
    in_valid = 1'b0;
    chk("rx_second_ready", 32'(in_ready), 32'd0);
    ld(A_RX, 32'hCD, "rx_second");

    // Asynchronous reset mid-drain with 3 words queued.
    st(A_TX, 32'd7);
    st(A_TX, 32'd8);
    st(A_TX, 32'd9);
    ld(A_STAT, 32'h0000_0304, "pre_reset_status");
    io_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("async_io_valid", 32'(io_valid), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    chk("async_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    io_ready = 1'b0;
    ld(A_STAT, 32'h0000_0002, "post_reset_status");
    ld(A_CYC, 32'h0, "post_reset_cycle");
    ld(32'h10, 32'h1234_5678, "ram_survives_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
